// File: rtl/pov_pkg.sv
// Shared constants and FSM state type for the POV column scanner.
package pov_pkg;

    localparam int NUM_CHARS = 11;
    localparam int CHAR_W    = 7;
    localparam int FONT_COLS = 5;
    localparam int GAP_COLS  = 1;
    localparam int STR_W     = NUM_CHARS * CHAR_W;

    localparam logic [CHAR_W-1:0] SPACE = 7'h20;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        DONE
    } state_t;

endpackage

// File: rtl/pov_font_rom.sv
// Combinational 5x7 glyph table: digits and uppercase letters, every other code blank.
import pov_pkg::*;

module pov_font_rom (
    input  logic [6:0] ch,
    input  logic [2:0] col,
    output logic [6:0] bits
);

    // Glyph packed leftmost column first; bit 0 of each column is the top row.
    logic [34:0] glyph;
    logic [34:0] shifted;

    always_comb begin
        glyph = '0;
        case (ch)
            SPACE: glyph = '0;
            7'h30: glyph = {7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E};
            7'h31: glyph = {7'h00, 7'h42, 7'h7F, 7'h40, 7'h00};
            7'h32: glyph = {7'h42, 7'h61, 7'h51, 7'h49, 7'h46};
            7'h33: glyph = {7'h21, 7'h41, 7'h45, 7'h4B, 7'h31};
            7'h34: glyph = {7'h18, 7'h14, 7'h12, 7'h7F, 7'h10};
            7'h35: glyph = {7'h27, 7'h45, 7'h45, 7'h45, 7'h39};
            7'h36: glyph = {7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30};
            7'h37: glyph = {7'h01, 7'h71, 7'h09, 7'h05, 7'h03};
            7'h38: glyph = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
            7'h39: glyph = {7'h06, 7'h49, 7'h49, 7'h29, 7'h1E};
            7'h41: glyph = {7'h7E, 7'h11, 7'h11, 7'h11, 7'h7E};
            7'h42: glyph = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h36};
            7'h43: glyph = {7'h3E, 7'h41, 7'h41, 7'h41, 7'h22};
            7'h44: glyph = {7'h7F, 7'h41, 7'h41, 7'h22, 7'h1C};
            7'h45: glyph = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h41};
            7'h46: glyph = {7'h7F, 7'h09, 7'h09, 7'h01, 7'h01};
            7'h47: glyph = {7'h3E, 7'h41, 7'h41, 7'h51, 7'h32};
            7'h48: glyph = {7'h7F, 7'h08, 7'h08, 7'h08, 7'h7F};
            7'h49: glyph = {7'h00, 7'h41, 7'h7F, 7'h41, 7'h00};
            7'h4A: glyph = {7'h20, 7'h40, 7'h41, 7'h3F, 7'h01};
            7'h4B: glyph = {7'h7F, 7'h08, 7'h14, 7'h22, 7'h41};
            7'h4C: glyph = {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40};
            7'h4D: glyph = {7'h7F, 7'h02, 7'h04, 7'h02, 7'h7F};
            7'h4E: glyph = {7'h7F, 7'h04, 7'h08, 7'h10, 7'h7F};
            7'h4F: glyph = {7'h3E, 7'h41, 7'h41, 7'h41, 7'h3E};
            7'h50: glyph = {7'h7F, 7'h09, 7'h09, 7'h09, 7'h06};
            7'h51: glyph = {7'h3E, 7'h41, 7'h51, 7'h21, 7'h5E};
            7'h52: glyph = {7'h7F, 7'h09, 7'h19, 7'h29, 7'h46};
            7'h53: glyph = {7'h46, 7'h49, 7'h49, 7'h49, 7'h31};
            7'h54: glyph = {7'h01, 7'h01, 7'h7F, 7'h01, 7'h01};
            7'h55: glyph = {7'h3F, 7'h40, 7'h40, 7'h40, 7'h3F};
            7'h56: glyph = {7'h1F, 7'h20, 7'h40, 7'h20, 7'h1F};
            7'h57: glyph = {7'h7F, 7'h20, 7'h18, 7'h20, 7'h7F};
            7'h58: glyph = {7'h63, 7'h14, 7'h08, 7'h14, 7'h63};
            7'h59: glyph = {7'h03, 7'h04, 7'h78, 7'h04, 7'h03};
            7'h5A: glyph = {7'h61, 7'h51, 7'h49, 7'h45, 7'h43};
            default: glyph = '0;
        endcase
    end

    assign shifted = glyph << (7 * col);
    assign bits    = (col < 3'd5) ? shifted[34:28] : 7'h00;

endmodule

// File: rtl/pov_column_scan.sv
// Per-revolution text sweep: snapshots the text on each sync rise and plays it out column by column.
import pov_pkg::*;

module pov_column_scan #(
    parameter int COL_TICKS = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STR_W-1:0]  text,
    input  logic              sync,
    output logic [CHAR_W-1:0] led,
    output logic              active
);

    localparam int TICK_W = $clog2(COL_TICKS);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(COL_TICKS - 1);
    localparam logic [2:0]        COL_LAST   = 3'(FONT_COLS + GAP_COLS - 1);
    localparam logic [2:0]        GLYPH_COLS = 3'(FONT_COLS);
    localparam logic [3:0]        CHAR_LAST  = 4'(NUM_CHARS - 1);

    logic sync_meta, sync_sync, sync_prev, sync_rise;

    state_t             state, state_nxt;
    logic [STR_W-1:0]   snap, snap_nxt, snap_shifted;
    logic [3:0]         char_idx, char_nxt;
    logic [2:0]         col_idx, col_nxt;
    logic [TICK_W-1:0]  tick, tick_nxt;
    logic [CHAR_W-1:0]  cur_ch, font_bits, led_nxt;

    assign sync_rise = sync_sync & ~sync_prev;

    always_comb begin
        state_nxt = state;
        snap_nxt  = snap;
        char_nxt  = char_idx;
        col_nxt   = col_idx;
        tick_nxt  = tick;
        if (sync_rise) begin
            state_nxt = SHOW;
            snap_nxt  = text;
            char_nxt  = '0;
            col_nxt   = '0;
            tick_nxt  = '0;
        end else if (state == SHOW) begin
            if (tick == TICK_LAST) begin
                tick_nxt = '0;
                if (col_idx == COL_LAST) begin
                    col_nxt = '0;
                    if (char_idx == CHAR_LAST) begin
                        state_nxt = DONE;
                        char_nxt  = '0;
                    end else begin
                        char_nxt = char_idx + 4'd1;
                    end
                end else begin
                    col_nxt = col_idx + 3'd1;
                end
            end else begin
                tick_nxt = tick + 1'b1;
            end
        end
    end

    // The LED register is loaded from next-state values so a new column appears on the same edge it begins.
    assign snap_shifted = snap_nxt << (CHAR_W * char_nxt);
    assign cur_ch       = snap_shifted[STR_W-1 -: CHAR_W];

    pov_font_rom u_font (
        .ch   (cur_ch),
        .col  (col_nxt),
        .bits (font_bits)
    );

    assign led_nxt = (state_nxt == SHOW && col_nxt < GLYPH_COLS) ? font_bits : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_sync <= 1'b0;
            sync_prev <= 1'b0;
            state     <= IDLE;
            snap      <= '0;
            char_idx  <= '0;
            col_idx   <= '0;
            tick      <= '0;
            led       <= '0;
            active    <= 1'b0;
        end else begin
            sync_meta <= sync;
            sync_sync <= sync_meta;
            sync_prev <= sync_sync;
            state     <= state_nxt;
            snap      <= snap_nxt;
            char_idx  <= char_nxt;
            col_idx   <= col_nxt;
            tick      <= tick_nxt;
            led       <= led_nxt;
            active    <= (state_nxt == SHOW);
        end
    end

endmodule

// File: tb/tb_pov_column_scan.sv
// Directed bench for pov_column_scan with a 4-cycle column period.
module tb_pov_column_scan;

    localparam int CT    = 4;
    localparam int SWEEP = 66 * CT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [76:0] text = {11{7'h20}};
    logic        sync = 1'b0;
    logic [6:0]  led;
    logic        active;

    int checks = 0;
    int errors = 0;

    logic [6:0] exp_tab [11][5];

    pov_column_scan #(.COL_TICKS(CT)) dut (
        .clk    (clk),
        .rst    (rst),
        .text   (text),
        .sync   (sync),
        .led    (led),
        .active (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 11; i++)
            for (int j = 0; j < 5; j++)
                exp_tab[i][j] = 7'h00;
    endtask

    task automatic set_glyph(input int idx, input logic [34:0] g);
        for (int j = 0; j < 5; j++) exp_tab[idx][j] = g[34 - 7*j -: 7];
    endtask

    function automatic logic [6:0] exp_led(input int c);
        int col, ch, cc;
        col = c / CT;
        ch  = col / 6;
        cc  = col % 6;
        return (cc < 5) ? exp_tab[ch][cc] : 7'h00;
    endfunction

    // Raise sync and leave the bench at sweep cycle 0 (two edges after the first sampling edge); sync stays high.
    task automatic start_sweep();
        sync = 1'b1;
        step(3);
    endtask

    task automatic check_cycles(input string tag, input int from, input int to);
        for (int c = from; c < to; c++) begin
            check($sformatf("%s_led_c%0d", tag, c), led, exp_led(c));
            check($sformatf("%s_act_c%0d", tag, c), active, 1'b1);
            step(1);
        end
    endtask

    task automatic check_done(input string tag);
        check($sformatf("%s_done_act", tag), active, 1'b0);
        check($sformatf("%s_done_led", tag), led, 7'h00);
        step(3);
        check($sformatf("%s_hold_act", tag), active, 1'b0);
        check($sformatf("%s_hold_led", tag), led, 7'h00);
    endtask

    initial begin
        step(3);
        check("reset_led", led, 7'h00);
        check("reset_act", active, 1'b0);
        rst = 1'b0;
        step(4);
        check("idle_led", led, 7'h00);
        check("idle_act", active, 1'b0);

        // all spaces
        clear_exp();
        text = {11{7'h20}};
        start_sweep();
        sync = 1'b0;
        check_cycles("spaces", 0, SWEEP);
        check_done("spaces");

        // 'A' in character 0, started from DONE
        text[76:70] = 7'h41;
        set_glyph(0, {7'h7E, 7'h11, 7'h11, 7'h11, 7'h7E});
        start_sweep();
        sync = 1'b0;
        check_cycles("charA", 0, SWEEP);
        check_done("charA");

        // text changes mid-sweep are ignored until the next sync
        start_sweep();
        sync = 1'b0;
        check_cycles("snapA", 0, 100);
        text[76:70] = 7'h42;
        check_cycles("snapA", 100, SWEEP);
        check_done("snapA");
        set_glyph(0, {7'h7F, 7'h49, 7'h49, 7'h49, 7'h36});
        start_sweep();
        sync = 1'b0;
        check_cycles("charB", 0, SWEEP);
        check_done("charB");

        // restart mid-sweep
        start_sweep();
        sync = 1'b0;
        check_cycles("pre_restart", 0, 98);
        start_sweep();
        sync = 1'b0;
        check_cycles("restart", 0, SWEEP);
        check_done("restart");

        // reset wins over a simultaneous sync rise
        start_sweep();
        sync = 1'b0;
        check_cycles("pre_rst", 0, 48);
        sync = 1'b1;
        step(2);
        rst  = 1'b1;
        sync = 1'b0;
        step(1);
        check("rst_led", led, 7'h00);
        check("rst_act", active, 1'b0);
        rst = 1'b0;
        step(6);
        check("post_rst_led", led, 7'h00);
        check("post_rst_act", active, 1'b0);

        // '1' in character 10, sync held high well into the sweep
        text = {11{7'h20}};
        text[6:0] = 7'h31;
        clear_exp();
        set_glyph(10, {7'h00, 7'h42, 7'h7F, 7'h40, 7'h00});
        start_sweep();
        check_cycles("char1", 0, 30);
        sync = 1'b0;
        check_cycles("char1", 30, SWEEP);
        check_done("char1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pov_column_scan.md
# pov_column_scan

Downstream consumer of the 77-bit, 11-character ASCII text register in the POV display. Once per revolution, on the hall-sensor `sync` pulse, it snapshots the text and steps through it left to right. For each character it emits five 7-bit font columns plus one blank gap column on `led`, each column held for a fixed number of clock cycles. When the sweep finishes, it blanks the LEDs until the next revolution.

## Interface
- `NUM_CHARS`, 11: characters in `string`.
- `CHAR_W`, 7: bits per character (7-bit ASCII).
- `FONT_COLS`, 5: glyph columns per character.
- `GAP_COLS`, 1: blank columns after each glyph.
- `COL_TICKS`, 1000: clock cycles each column is held (≥2).

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `string`, in, 77: text register. Bits [76:70] are character 0, the leftmost and oldest. Bits [6:0] are character 10, the newest.
- `sync`, in, 1: hall-sensor pulse, asynchronous, active-high, at least 3 `clk` cycles wide.
- `led`, out, 7: current column, registered. Bit 0 is the top row, and 1 means lit.
- `active`, out, 1: high while a sweep is in progress, registered.

## Operation
- `sync` passes through a 2-flop synchronizer and then a rising-edge detector. The edge detector produces `sync_rise`.
- FSM states:
  - IDLE: after reset. `led`=0, `active`=0. `sync_rise` moves to SHOW.
  - SHOW: sweep in progress. `active`=1.
  - DONE: sweep complete. `led`=0, `active`=0. `sync_rise` moves to SHOW.
- On entering SHOW:
  - `string` is latched into `snap`.
  - `char_idx`, `col_idx` and `tick` are cleared.
  - `snap` does not change again until the next SHOW entry.
- In SHOW, `tick` counts 0..COL_TICKS-1. At COL_TICKS-1, `tick` wraps to 0 and the column advances:
  - `col_idx` counts 0..FONT_COLS+GAP_COLS-1, then wraps to 0 and `char_idx` increments.
  - After the last column of `char_idx`=NUM_CHARS-1, the FSM goes to DONE.
- Column output:
  - When `col_idx` < FONT_COLS, `led` = font(`snap` char `char_idx`, `col_idx`).
  - Otherwise `led` = 0 (gap column).
- Font coverage:
  - 0x20 (space) is all zero.
  - '0'–'9' and 'A'–'Z' use the standard 5x7 glyphs.
  - Every other code, including lowercase, is blank.
- A `sync_rise` while in SHOW restarts the sweep: new snapshot, counters cleared, state stays SHOW. The remainder of the old sweep is discarded.
- Changes to `string` during a sweep have no effect until the next `sync_rise`.
- Reset has priority over everything, including a simultaneous `sync_rise`. Reset mid-sweep returns to IDLE with `led`=0 and `active`=0.

## Timing
- Reset values:
  - `led`=0, `active`=0, state IDLE.
  - All counters 0, `snap`=0.
  - Synchronizer and edge flops = 0.
- Latency:
  - `sync` first sampled high at edge k.
  - `sync_rise` is valid during the cycle after edge k+1.
  - At edge k+2, `led` shows column 0 of character 0 and `active`=1.
- Every column is held exactly COL_TICKS cycles. A full sweep lasts NUM_CHARS·(FONT_COLS+GAP_COLS)·COL_TICKS cycles, which is 66·COL_TICKS at the defaults.
- At the edge ending the last gap column, `led`→0 and `active`→0 (DONE).
- `sync` held high does not retrigger. Only a low→high transition after synchronization counts.

## Structure
- Package `pov_pkg`:
  - Constants `NUM_CHARS`, `CHAR_W`, `FONT_COLS`, `GAP_COLS`.
  - Total string width `STR_W` = NUM_CHARS·CHAR_W = 77.
  - ASCII constant `SPACE` = 7'h20.
  - FSM state enum `{IDLE, SHOW, DONE}`.
- Sub-module `pov_font_rom`: purely combinational. Inputs are `ch` [6:0] and `col` [2:0]; output is `bits` [6:0]. This separates the glyph table from the sequencing logic.
- Character selection from `snap` is a shift or index: char `i` occupies bits [76-7i : 70-7i].

## Test plan
All scenarios use COL_TICKS=4.
1. Reset, then `sync` pulse with `string` all spaces (0x20×11) → `active` high for 264 cycles, then low; `led`=0 throughout.
2. Character 0 = 'A' (0x41), rest spaces; `sync` pulse → starting 2 edges after `sync` is sampled, `led` = 0x7E, 0x11, 0x11, 0x11, 0x7E for 4 cycles each, then 0x00 for the remaining 244 cycles.
3. Character 10 = '1' (0x31), rest spaces → `led` nonzero only during cycles 240–259 of the sweep, with columns 0x00, 0x42, 0x7F, 0x40, 0x00; `active` drops at cycle 264.
4. Change `string` from 'A' to 'B' in character 0 mid-sweep → current sweep keeps showing 'A'. The next `sync` shows 'B': 0x7F, 0x49, 0x49, 0x49, 0x36.
5. Second `sync` rise at cycle 100 of a sweep → `led` restarts at column 0 of character 0 two edges later; the full 264-cycle sweep runs from there.
6. Assert `rst` at cycle 50 of a sweep, together with a `sync` rise → next edge `led`=0, `active`=0, state IDLE. A later `sync` starts a normal sweep.
